ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Boot-time program loader sitting directly upstream of the CPU core and its RAM.
//  Holds the CPU in reset, zero-fills a RAM address range, then writes a program
//  byte stream (valid/ready) into RAM from address 0.
//  Releases CPU reset after a fixed delay. Hardware replacement for the bench-side
//  RAM clear, preload and reset-release sequence.
// PARAMETERS
//  ADDR_WIDTH     4   RAM address width; RAM depth = 2**ADDR_WIDTH
//  DATA_WIDTH     8   RAM word / stream byte width
//  CLEAR_START    0   first address zero-filled (inclusive)
//  CLEAR_END      15  last address zero-filled (inclusive); CLEAR_START <= CLEAR_END < depth
//  RELEASE_DELAY  2   cycles cpu_reset stays high after load completes (>=1)
// PORTS
//  clk         in   1           system clock, all state on rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  start       in   1           one-cycle pulse: begin clear+load sequence
//  in_valid    in   1           stream byte valid
//  in_data     in   DATA_WIDTH  stream byte
//  in_last     in   1           marks final byte of program
//  in_ready    out  1           loader accepts byte this cycle
//  ram_we      out  1           RAM write enable (registered)
//  ram_addr    out  ADDR_WIDTH  RAM write address (registered)
//  ram_wdata   out  DATA_WIDTH  RAM write data (registered)
//  cpu_reset   out  1           active-high reset to CPU core
//  busy        out  1           high in CLEAR, LOAD, RELEASE
//  done        out  1           high in RUN (CPU released)
//  overflow    out  1           sticky: program longer than RAM; cleared on start
//  load_count  out  ADDR_WIDTH+1 bytes written during LOAD
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   state=IDLE, cpu_reset=1, ram_we=0, ram_addr=0, ram_wdata=0, in_ready=0,
//   busy=0, done=0, overflow=0, load_count=0.
//   Mid-sequence reset aborts immediately; cpu_reset is 1 with no clock edge.
//  FSM: IDLE -> CLEAR -> LOAD -> RELEASE -> RUN.
//  IDLE: cpu_reset=1. start=1 -> CLEAR at next edge.
//  CLEAR: one write per cycle, ram_we=1, ram_wdata=0.
//   ram_addr steps CLEAR_START..CLEAR_END; takes CLEAR_END-CLEAR_START+1 cycles.
//   After the write to CLEAR_END -> LOAD; load pointer=0.
//  LOAD: in_ready=1 combinationally from state==LOAD. Byte accepted on in_valid&&in_ready.
//   Write latency 1: the cycle after acceptance, ram_we=1, ram_addr=ptr, ram_wdata=byte.
//   ptr and load_count then increment. No accept -> ram_we=0 next cycle.
//   Accepted in_last=1 -> RELEASE; that byte is still written.
//   Byte accepted at ptr=depth-1 with in_last=0: byte is written, overflow<=1,
//   -> RELEASE. Pointer never wraps.
//   in_valid outside LOAD is ignored (in_ready=0).
//  RELEASE: cpu_reset=1 for RELEASE_DELAY cycles (the final LOAD write completes in the
//   first cycle), then RUN.
//  RUN: cpu_reset=0, done=1, busy=0.
//   start=1 -> CLEAR; at that edge cpu_reset=1, done=0, overflow=0, load_count=0.
//  start is ignored in CLEAR, LOAD and RELEASE.
//  Outputs are registered except in_ready.
// TESTING
//  1 reset_n=0 mid-LOAD (after 3 bytes) -> cpu_reset=1 at once, state IDLE,
//    all outputs at reset values, further in_valid ignored.
//  2 start, defaults -> 16 writes of 0x00 at addr 0..15 on consecutive cycles,
//    then in_ready=1.
//  3 Stream 0x1E,0x2F,0xF0 with last on 0xF0 -> RAM[0..2]=1E,2F,F0, RAM[3..15]=00,
//    load_count=3. cpu_reset falls 2 cycles after the last accept; done=1.
//    Bench run_until_halt completes.
//  4 in_valid toggled 1,0,0,1 with bytes A5,5A (last) -> exactly 2 writes.
//    Each write lands one cycle after its accept; no write on idle cycles.
//  5 17 bytes without last -> 16 writes, overflow=1 after the 16th;
//    17th byte not accepted (in_ready=0), no write to addr 0; done follows.
//  6 start asserted in LOAD -> ignored.
//    start in RUN -> cpu_reset=1 next cycle, overflow cleared, re-clear begins.

Source files
------------

// File: rtl/ram_loader_if.sv
// Stream-in and RAM-write bundle for the boot loader.
// master: the side that sources program bytes and observes RAM writes.
// slave : the loader itself.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_loader.sv
// Boot-time program loader: holds the CPU in reset, zero-fills a RAM range,
// streams a program into RAM from address 0, then releases the CPU after a
// short delay. All outputs are registered except in_ready.
module ram_loader #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int CLEAR_START   = 0,
  parameter int CLEAR_END     = 15,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  ram_loader_if.slave         bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_WIDTH:0] load_count
);

  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(CLEAR_START);
  localparam logic [ADDR_WIDTH-1:0] END_ADDR   = ADDR_WIDTH'(CLEAR_END);
  // Pointer value of the last RAM word; a non-final byte here means overflow.
  localparam logic [ADDR_WIDTH:0]   LAST_PTR   = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);
  localparam int                    RW         = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [RW-1:0]         REL_LAST   = RW'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RELEASE,
    RUN
  } state_t;

  state_t        state;
  logic [RW-1:0] rel_cnt;

  // The stream is accepted in every LOAD cycle; no backpressure within LOAD.
  assign bus.in_ready = (state == LOAD);

  // Sequencer: clear, load, release; every write and status flag is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rel_cnt       <= '0;
      cpu_reset     <= 1'b1;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      load_count    <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state         <= CLEAR;
            cpu_reset     <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            overflow      <= 1'b0;
            load_count    <= '0;
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= START_ADDR;
            bus.ram_wdata <= '0;
          end
        end

        CLEAR: begin
          if (bus.ram_addr == END_ADDR) begin
            state      <= LOAD;
            bus.ram_we <= 1'b0;
            load_count <= '0;
          end else begin
            bus.ram_addr <= bus.ram_addr + 1'b1;
          end
        end

        LOAD: begin
          if (bus.in_valid) begin
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= load_count[ADDR_WIDTH-1:0];
            bus.ram_wdata <= bus.in_data;
            load_count    <= load_count + 1'b1;
            if (bus.in_last || (load_count == LAST_PTR)) begin
              state   <= RELEASE;
              rel_cnt <= '0;
              if (!bus.in_last) begin
                overflow <= 1'b1;
              end
            end
          end else begin
            bus.ram_we <= 1'b0;
          end
        end

        RELEASE: begin
          bus.ram_we <= 1'b0;
          if (rel_cnt == REL_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader. Expected RAM writes (cycle, address, data)
// are queued when stimulus is driven and checked as the DUT issues them.
module tb_ram_loader;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_reset, busy, done, overflow;
  logic [AW:0]   load_count;

  ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_START(0), .CLEAR_END(15), .RELEASE_DELAY(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .load_count(load_count)
  );

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          exp_ptr = 0;
  logic [31:0] cyc = '0;
  wr_t         sb[$];
  logic [DW-1:0] mem [DEPTH];

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  // Cycle index used to timestamp expected writes.
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Behavioural RAM that the loader writes into.
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes = passes + 1;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every RAM write must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    wr_t want;
    wr_t got;
    if (reset_n && bus.ram_we) begin
      checkOutput("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        want = sb.pop_front();
        got  = {cyc, bus.ram_addr, bus.ram_wdata};
        checkOutput("ram_write", 64'(got), 64'(want));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l, input logic exp_ready);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    checkOutput("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    if (v && exp_ready) begin
      sb.push_back({cyc + 32'd1, exp_ptr[AW-1:0], d});
      exp_ptr++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back({cyc + 32'(i), i[AW-1:0], 8'h00});
    end
    exp_ptr = 0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_cpu_reset",  64'(cpu_reset),     64'd1);
    checkOutput("rst_ram_we",     64'(bus.ram_we),    64'd0);
    checkOutput("rst_ram_addr",   64'(bus.ram_addr),  64'd0);
    checkOutput("rst_ram_wdata",  64'(bus.ram_wdata), 64'd0);
    checkOutput("rst_in_ready",   64'(bus.in_ready),  64'd0);
    checkOutput("rst_busy",       64'(busy),          64'd0);
    checkOutput("rst_done",       64'(done),          64'd0);
    checkOutput("rst_overflow",   64'(overflow),      64'd0);
    checkOutput("rst_load_count", 64'(load_count),    64'd0);
  endtask

  initial begin
    logic [DW-1:0] prog [DEPTH];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;

    repeat (2) tick();
    checkResetValues();
    reset_n = 1'b1;
    tick();

    $display("[TB] abort in LOAD");
    doStart();
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1 checkResetValues();
    checkOutput("sb_after_abort", 64'(sb.size()), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);

    $display("[TB] clear then load 1E 2F F0");
    doStart();
    checkOutput("clear_busy", 64'(busy), 64'd1);
    checkOutput("clear_cpu_reset", 64'(cpu_reset), 64'd1);
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) checkOutput($sformatf("cleared_%0d", i), 64'(mem[i]), 64'd0);
    applyStimulus(1'b1, 8'h1E, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h2F, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hF0, 1'b1, 1'b1);
    checkOutput("rel0_cpu_reset", 64'(cpu_reset), 64'd1);
    checkOutput("rel0_busy", 64'(busy), 64'd1);
    tick();
    checkOutput("rel1_cpu_reset", 64'(cpu_reset), 64'd1);
    tick();
    checkOutput("run_cpu_reset", 64'(cpu_reset), 64'd0);
    checkOutput("run_done", 64'(done), 64'd1);
    checkOutput("run_busy", 64'(busy), 64'd0);
    checkOutput("run_load_count", 64'(load_count), 64'd3);
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hF0;
    for (int i = 0; i < DEPTH; i++) checkOutput($sformatf("prog_%0d", i), 64'(mem[i]), 64'(prog[i]));

    $display("[TB] restart from RUN, gapped stream, start in LOAD");
    doStart();
    checkOutput("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    checkOutput("restart_done", 64'(done), 64'd0);
    checkOutput("restart_load_count", 64'(load_count), 64'd0);
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    start = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    start = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("gap_done", 64'(done), 64'd1);
    checkOutput("gap_load_count", 64'(load_count), 64'd2);
    checkOutput("gap_mem0", 64'(mem[0]), 64'hA5);
    checkOutput("gap_mem1", 64'(mem[1]), 64'h5A);
    checkOutput("gap_mem2", 64'(mem[2]), 64'h00);

    $display("[TB] overflow with 17 bytes");
    doStart();
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_load_count", 64'(load_count), 64'd16);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_done", 64'(done), 64'd1);
    checkOutput("ovf_cpu_reset", 64'(cpu_reset), 64'd0);
    checkOutput("ovf_mem0", 64'(mem[0]), 64'h40);
    checkOutput("ovf_mem15", 64'(mem[15]), 64'h4F);

    doStart();
    checkOutput("start_clears_overflow", 64'(overflow), 64'd0);
    checkOutput("start_cpu_reset", 64'(cpu_reset), 64'd1);
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
